// File: rtl/ss_read_buffer_if.sv
// Stream and sequencer-side bundle of the read buffer.
// The slave modport is the buffer; master is whatever drives the sequencer/BRAM/consumer side.
interface ss_read_buffer_if #(
  parameter int SIZE_DATA = 8,
  parameter int DEPTH     = 8
);
  logic                   start_read_data;
  logic                   re_ram;
  logic [SIZE_DATA-1:0]   rdata_ram;
  logic                   done_read_data;
  logic                   en_read_data;
  logic [SIZE_DATA-1:0]   data;
  logic                   valid;
  logic                   ready;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   done;

  modport master (
    output start_read_data, re_ram, rdata_ram, done_read_data, ready,
    input  en_read_data, data, valid, count, overflow, done
  );

  modport slave (
    input  start_read_data, re_ram, rdata_ram, done_read_data, ready,
    output en_read_data, data, valid, count, overflow, done
  );
endinterface

// File: rtl/ss_read_buffer.sv
// Captures latency-aligned BRAM read data into a first-word-fall-through FIFO,
// throttles the address sequencer and flags end of transfer.
module ss_read_buffer #(
  parameter int SIZE_DATA  = 8,
  parameter int DEPTH      = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  ss_read_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [SIZE_DATA-1:0] mem_reg [DEPTH];
  logic                 vpipe_reg [RD_LATENCY];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic                 start_q_reg;
  logic                 overflow_reg;
  logic                 done_seen_reg;
  logic                 done_reg;
  logic                 en_reg;

  logic                 start_edge;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 push_ok;
  logic                 not_empty;
  logic                 pipe_busy;
  logic [CW:0]          pending;
  logic [CW:0]          free_words;
  logic                 en_next;

  assign start_edge = bus.start_read_data & ~start_q_reg;
  assign not_empty  = (count_reg != '0);
  assign full       = (count_reg == CW'(DEPTH));
  assign push       = vpipe_reg[RD_LATENCY-1];
  assign pop        = not_empty & bus.ready;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok    = push & (~full | pop);

  // Read-strobe pipeline: the last stage marks the cycle i_rdata_ram is valid.
  for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_vpipe
    if (gi == 0) begin : g_head
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)           vpipe_reg[gi] <= 1'b0;
        else if (start_edge) vpipe_reg[gi] <= 1'b0;
        else                 vpipe_reg[gi] <= bus.re_ram;
      end
    end else begin : g_tail
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)           vpipe_reg[gi] <= 1'b0;
        else if (start_edge) vpipe_reg[gi] <= 1'b0;
        else                 vpipe_reg[gi] <= vpipe_reg[gi-1];
      end
    end
  end

  always_comb begin
    pending   = (CW+1)'(bus.re_ram);
    pipe_busy = 1'b0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      pending   = pending + (CW+1)'(vpipe_reg[i]);
      pipe_busy = pipe_busy | vpipe_reg[i];
    end
  end

  // Reads still in flight must find room, plus slack for the sequencer's registered strobe.
  assign free_words = (CW+1)'(DEPTH) - {1'b0, count_reg};
  assign en_next    = (free_words >= pending) &&
                      ((free_words - pending) >= (CW+1)'(RD_LATENCY + 2));

  always_ff @(posedge i_clk) begin
    if (push_ok && !start_edge) mem_reg[wr_ptr_reg] <= bus.rdata_ram;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      start_q_reg   <= 1'b0;
      overflow_reg  <= 1'b0;
      done_seen_reg <= 1'b0;
      done_reg      <= 1'b0;
      en_reg        <= 1'b0;
    end else begin
      start_q_reg <= bus.start_read_data;
      en_reg      <= en_next;
      if (start_edge) begin
        wr_ptr_reg    <= '0;
        rd_ptr_reg    <= '0;
        count_reg     <= '0;
        overflow_reg  <= 1'b0;
        done_seen_reg <= 1'b0;
        done_reg      <= 1'b0;
      end else begin
        if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
        case ({push_ok, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
        if (push && full && !pop) overflow_reg  <= 1'b1;
        if (bus.done_read_data)   done_seen_reg <= 1'b1;
        done_reg <= done_seen_reg & ~not_empty & ~pipe_busy & ~bus.re_ram;
      end
    end
  end

  assign bus.valid        = not_empty;
  assign bus.data         = not_empty ? mem_reg[rd_ptr_reg] : '0;
  assign bus.count        = count_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.done         = done_reg;
  assign bus.en_read_data = en_reg;

endmodule

// File: tb/tb_ss_read_buffer.sv
// Bench for ss_read_buffer: queue-based reference model, directed table, corner sequences
// and random-ready streams on a RD_LATENCY=1 and a RD_LATENCY=2 instance.
module tb_ss_read_buffer;

  localparam int DEPTH = 8;

  typedef struct {
    bit         re;
    bit         ready;
    bit         dn;
    bit         ev;
    logic [7:0] ed;
    int         ec;
    bit         edone;
  } vec_t;

  typedef struct {
    int         issue;
    logic [7:0] d;
  } flight_t;

  logic clk;
  logic rst;
  bit   sel;
  logic start, re, done_rd, ready;
  logic [7:0] rdata1, rdata2;

  logic       valid_o, en_o, ovf_o, done_o;
  logic [7:0] data_o;
  logic [3:0] count_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [64];
  int   addr, next_addr, remaining, a1, a2;
  bit   en_prev, en_cur;
  logic [7:0] popped [$];
  logic [7:0] exp_q [$];

  logic [7:0] m_fifo [$];
  flight_t    m_fl [$];
  bit m_ovf, m_dseen, m_done, m_en, m_startq;
  int m_cyc;

  ss_read_buffer_if #(.SIZE_DATA(8), .DEPTH(DEPTH)) bus0 ();
  ss_read_buffer_if #(.SIZE_DATA(8), .DEPTH(DEPTH)) bus1 ();

  assign bus0.start_read_data = start   & ~sel;
  assign bus0.re_ram          = re      & ~sel;
  assign bus0.done_read_data  = done_rd & ~sel;
  assign bus0.ready           = ready   & ~sel;
  assign bus0.rdata_ram       = rdata1;
  assign bus1.start_read_data = start   & sel;
  assign bus1.re_ram          = re      & sel;
  assign bus1.done_read_data  = done_rd & sel;
  assign bus1.ready           = ready   & sel;
  assign bus1.rdata_ram       = rdata2;

  assign valid_o = sel ? bus1.valid        : bus0.valid;
  assign data_o  = sel ? bus1.data         : bus0.data;
  assign count_o = sel ? bus1.count        : bus0.count;
  assign ovf_o   = sel ? bus1.overflow     : bus0.overflow;
  assign done_o  = sel ? bus1.done         : bus0.done;
  assign en_o    = sel ? bus1.en_read_data : bus0.en_read_data;

  ss_read_buffer #(.SIZE_DATA(8), .DEPTH(DEPTH), .RD_LATENCY(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .bus(bus0)
  );
  ss_read_buffer #(.SIZE_DATA(8), .DEPTH(DEPTH), .RD_LATENCY(2)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic void model_reset();
    m_fifo.delete();
    m_fl.delete();
    m_ovf = 0; m_dseen = 0; m_done = 0; m_en = 0; m_startq = 0;
  endfunction

  // One clock of the specified behaviour, evaluated on the pre-edge state.
  function automatic void model_step();
    bit se, pop, push, n_en, n_done;
    int pend, free, lat;
    flight_t f;
    lat    = sel ? 2 : 1;
    se     = start && !m_startq;
    m_startq = start;
    pend   = m_fl.size() + int'(re);
    free   = DEPTH - m_fifo.size();
    n_en   = (free - pend) >= (lat + 2);
    n_done = m_dseen && m_fifo.size() == 0 && m_fl.size() == 0 && !re;
    pop    = m_fifo.size() != 0 && ready;
    push   = m_fl.size() != 0 && m_fl[0].issue == m_cyc - lat;
    if (se) begin
      m_fifo.delete();
      m_fl.delete();
      m_ovf = 0; m_dseen = 0; n_done = 0;
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (push) begin
        f = m_fl.pop_front();
        if (m_fifo.size() < DEPTH) m_fifo.push_back(f.d);
        else m_ovf = 1;
      end
      if (re) begin
        f.issue = m_cyc;
        f.d = ram[addr];
        m_fl.push_back(f);
      end
      if (done_rd) m_dseen = 1;
    end
    m_en = n_en;
    m_done = n_done;
    m_cyc++;
  endfunction

  task automatic check_model();
    chk("model_valid", valid_o, int'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) chk("model_data", data_o, m_fifo[0]);
    chk("model_count", count_o, m_fifo.size());
    chk("model_overflow", ovf_o, m_ovf);
    chk("model_done", done_o, m_done);
    chk("model_en", en_o, m_en);
  endtask

  // Inputs for the current cycle are already set; BRAM output follows address history.
  task automatic tick();
    rdata1 = ram[a1];
    rdata2 = ram[a2];
    if (valid_o && ready) begin
      popped.push_back(data_o);
      $display("pop dut%0d data=0x%02h count=%0d", sel, data_o, count_o);
    end
    @(posedge clk);
    model_step();
    a2 = a1;
    a1 = addr;
    @(negedge clk);
    check_model();
    en_prev = en_cur;
    en_cur  = en_o;
  endtask

  task automatic drive_read(input bit r);
    re = r;
    if (r) begin
      addr = next_addr;
      next_addr++;
      remaining--;
    end
  endtask

  // Sequencer: read strobe is a registered copy of last cycle's enable.
  task automatic seq_cycle();
    if (remaining > 0 && en_prev) drive_read(1'b1);
    else re = 1'b0;
    done_rd = (remaining <= 0) && !re;
  endtask

  task automatic start_transfer(input int n, input int base, input bit rnd);
    for (int i = 0; i < 64; i++) ram[i] = rnd ? 8'($urandom) : 8'(base + i);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(ram[i]);
    popped.delete();
    next_addr = 0; remaining = n;
    re = 0; done_rd = 0; ready = 0; start = 1;
    tick();
    start = 0;
  endtask

  task automatic check_order(input string name);
    int n;
    chk({name, "_words"}, popped.size(), exp_q.size());
    n = (popped.size() < exp_q.size()) ? popped.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, "_order"}, popped[i], exp_q[i]);
  endtask

  task automatic run_transfer(input int mode, input int bound, input string name);
    int k = 0;
    while (!done_o && k < bound) begin
      seq_cycle();
      ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
      tick();
      k++;
    end
    chk({name, "_done"}, done_o, 1);
    check_order(name);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, valid_o, 0);
    chk({name, "_data"}, data_o, 0);
    chk({name, "_count"}, count_o, 0);
    chk({name, "_overflow"}, ovf_o, 0);
    chk({name, "_done"}, done_o, 0);
    chk({name, "_en"}, en_o, 0);
  endtask

  vec_t tbl [9];

  initial begin
    bit saw_low;
    logic [7:0] head;

    tbl[0] = '{1, 1, 0, 0, 8'h00, 0, 0};
    tbl[1] = '{1, 1, 0, 1, 8'h11, 1, 0};
    tbl[2] = '{1, 1, 0, 1, 8'h12, 1, 0};
    tbl[3] = '{1, 1, 0, 1, 8'h13, 1, 0};
    tbl[4] = '{1, 1, 0, 1, 8'h14, 1, 0};
    tbl[5] = '{0, 1, 1, 1, 8'h15, 1, 0};
    tbl[6] = '{0, 1, 0, 0, 8'h00, 0, 0};
    tbl[7] = '{0, 1, 0, 0, 8'h00, 0, 1};
    tbl[8] = '{0, 1, 0, 0, 8'h00, 0, 1};

    sel = 0; rst = 1; start = 0; re = 0; done_rd = 0; ready = 0;
    addr = 0; next_addr = 0; remaining = 0; a1 = 0; a2 = 0;
    en_prev = 0; en_cur = 0; m_cyc = 0;
    for (int i = 0; i < 64; i++) ram[i] = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    repeat (2) tick();

    // 1: five-word stream, consumer always ready
    for (int i = 0; i < 64; i++) ram[i] = 8'(8'h11 + i);
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(ram[i]);
    popped.delete(); next_addr = 0;
    for (int r = 0; r < 9; r++) begin
      drive_read(tbl[r].re);
      ready = tbl[r].ready;
      done_rd = tbl[r].dn;
      tick();
      chk("t1_valid", valid_o, tbl[r].ev);
      if (tbl[r].ev) chk("t1_data", data_o, tbl[r].ed);
      chk("t1_count", count_o, tbl[r].ec);
      chk("t1_done", done_o, tbl[r].edone);
    end
    check_order("t1");

    // 2: stalled consumer, twelve words
    start_transfer(12, 8'h30, 0);
    saw_low = 0;
    for (int k = 0; k < 30; k++) begin
      seq_cycle();
      ready = 0;
      tick();
      if (!en_o) saw_low = 1;
    end
    chk("t2_en_fell", saw_low, 1);
    chk("t2_count_le8", int'(count_o <= 8), 1);
    chk("t2_overflow", ovf_o, 0);
    chk("t2_stalled", int'(remaining > 0), 1);
    run_transfer(1, 200, "t2");

    // 3: full FIFO with push and pop in the same cycle
    start_transfer(9, 8'h50, 0);
    for (int k = 0; k < 9; k++) begin
      drive_read(1'b1);
      ready = 0;
      tick();
    end
    chk("t3_full", count_o, 8);
    drive_read(1'b0);
    ready = 1;
    head = data_o;
    chk("t3_pop_word", head, 8'h50);
    tick();
    chk("t3_count_after", count_o, 8);
    chk("t3_overflow", ovf_o, 0);
    chk("t3_next_head", data_o, 8'h51);
    run_transfer(1, 100, "t3");

    // 4: reads forced past a full FIFO
    start_transfer(8, 8'h70, 0);
    for (int k = 0; k < 10; k++) begin
      drive_read(1'b1);
      ready = 0;
      tick();
    end
    drive_read(1'b0);
    tick();
    chk("t4_overflow", ovf_o, 1);
    chk("t4_count", count_o, 8);
    run_transfer(1, 100, "t4");

    // 5: restart mid-transfer with reads in flight
    start_transfer(12, 8'h90, 0);
    for (int k = 0; k < 40 && count_o != 5; k++) begin
      seq_cycle();
      ready = 0;
      tick();
    end
    chk("t5_reach5", count_o, 5);
    start_transfer(4, 8'hA0, 0);
    chk("t5_flush_count", count_o, 0);
    chk("t5_flush_valid", valid_o, 0);
    chk("t5_flush_done", done_o, 0);
    run_transfer(1, 100, "t5");

    // 6: random consumer, latency 1 then latency 2, then reset mid-stream
    start_transfer(40, 0, 1);
    run_transfer(2, 600, "t6a");

    re = 0; done_rd = 0; ready = 0; start = 0;
    sel = 1;
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    a1 = 0; a2 = 0; en_prev = 0; en_cur = 0;
    start_transfer(40, 0, 1);
    run_transfer(2, 600, "t6b");

    start_transfer(30, 0, 1);
    for (int k = 0; k < 25; k++) begin
      seq_cycle();
      ready = 1'($urandom_range(0, 1));
      tick();
    end
    #2 rst = 1;
    #1 chk_zero("t6_rst");
    @(negedge clk);
    rst = 0;
    model_reset();
    en_prev = 0; en_cur = 0;
    re = 0; done_rd = 0; ready = 1;
    popped.delete();
    repeat (5) tick();
    chk("t6_no_words", popped.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
